dmem_access_unit: RTL and testbench

Multi-cycle data-memory access unit for the miniRISC datapath. It accepts one load or store request per handshake, models fixed memory wait states, and returns a one-cycle response. The load word it returns is the memory-side source that the write-back select routes into the register file. It owns the 32-bit word data memory array. It also gives the control unit a `busy` indication so it can stall the pipeline.

---
 rtl/dmem_access_unit.sv | 132 +++++++++++++
 tb/tb_dmem_access_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// miniRISC data-memory access unit: handshaked load/store, fixed wait states, one-cycle response.
// Define DMEM_ALIGN_CHECK_EN to enable the misaligned-access fault response.
module dmem_access_unit #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                we_q;
  logic                fault_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [31:0]         mem [DEPTH];
  logic                accept;
  logic                misaligned;
  logic                access_en;
  logic                unused_addr;

  // Address bits outside the word index never reach the array, so the access wraps modulo depth.
`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned  = |req_addr[1:0];
  assign unused_addr = ^req_addr[31:ADDR_W+2];
`else
  assign misaligned  = 1'b0;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

  // Ready is a pure state decode, so req_valid never loops back into it.
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access is folded into the response cycle.
  if (LATENCY > 0) begin : g_wait_access
    assign access_en = (state == WAIT) && (cnt == 4'd0);
  end else begin : g_resp_access
    assign access_en = (state == RESP) && !fault_q;
  end

  // NOTE: next state defaults to the current state before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (misaligned || LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every clocked register uses non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        fault_q <= misaligned;
        idx_q   <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Response strobe and busy lag the state register by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      busy      <= (state != IDLE);
      rsp_valid <= (state == RESP);
      if (state == RESP) begin
        rsp_fault <= fault_q;
      end
      if (access_en) begin
        rsp_rdata <= we_q ? 32'd0 : mem[idx_q];
      end else if (state == RESP && fault_q) begin
        rsp_rdata <= '0;
      end
    end
  end

  // NOTE: the array itself has no reset; clearing it would break RAM inference and contents survive rst.
  always_ff @(posedge clk) begin
    if (access_en && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: vector table plus handshake, reset and zero-latency sequences.
// Expectations follow DMEM_ALIGN_CHECK_EN when the bundle is built with it.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready, rsp_valid, rsp_fault, busy;
  logic [31:0] rsp_rdata;
  logic        z_req_ready, z_rsp_valid, z_rsp_fault, z_busy;
  logic [31:0] z_rsp_rdata;

  logic        use_z = 1'b0;
  logic        m_ready, m_valid, m_fault;
  logic [31:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  dmem_access_unit #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .busy(busy)
  );

  dmem_access_unit #(.ADDR_W(10), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(z_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_fault(z_rsp_fault), .busy(z_busy)
  );

  assign m_ready = use_z ? z_req_ready : req_ready;
  assign m_valid = use_z ? z_rsp_valid : rsp_valid;
  assign m_fault = use_z ? z_rsp_fault : rsp_fault;
  assign m_rdata = use_z ? z_rsp_rdata : rsp_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request to the selected DUT; lat counts negedges from the accept edge to the strobe.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic fault,
                        output logic single);
    int n;
    n      = 0;
    lat    = 0;
    rdata  = '0;
    fault  = 1'b0;
    single = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_valid) begin
        lat   = i;
        rdata = m_rdata;
        fault = m_fault;
        break;
      end
    end
    @(negedge clk);
    single = !m_valid;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        fault;
    logic        single;
    int          first, second, low, pulses;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 4};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 4};
    vecs[2] = '{1'b1, 32'h0000_1004, 32'h0000_1234, 32'h0, 1'b0, 4};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_1234, 1'b0, 4};
    vecs[4] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 4};
    vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0, 4};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[6] = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1, 2};
    vecs[7] = '{1'b1, 32'h0000_0012, 32'h0000_0055, 32'h0, 1'b1, 2};
    vecs[8] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 4};
    vecs[9] = '{1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 4};
`else
    vecs[6] = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0, 4};
    vecs[7] = '{1'b1, 32'h0000_0012, 32'h0000_0055, 32'h0, 1'b0, 4};
    vecs[8] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0055, 1'b0, 4};
    vecs[9] = '{1'b0, 32'h8000_0010, 32'h0,         32'h0000_0055, 1'b0, 4};
`endif

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #3;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset z req_ready", 32'(z_req_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rdata, fault, single);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      check($sformatf("v%0d one-cycle strobe", i), 32'(single), 32'd1);
    end

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0010;
    first     = -1;
    second    = -1;
    low       = 0;
    for (int i = 0; i < 20 && second < 0; i++) begin
      if (req_ready) begin
        if (first < 0) first = i;
        else second = i;
      end else if (first >= 0) begin
        low++;
      end
      if (second < 0) @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = '0;
    check("b2b accept spacing", 32'(second - first), 32'd4);
    check("b2b ready low cycles", 32'(low), 32'd3);
    repeat (8) @(negedge clk);

    // Reset during the wait states of a store.
    do_req(1'b1, 32'h0000_0020, 32'h1111_2222, lat, rdata, fault, single);
    check("pre store latency", 32'(lat), 32'd4);
    do_req(1'b0, 32'h0000_0020, 32'h0, lat, rdata, fault, single);
    check("pre load rdata", rdata, 32'h1111_2222);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid-store busy", 32'(busy), 32'd1);
    check("mid-store ready", 32'(req_ready), 32'd0);
    check("mid-store rdata held", rsp_rdata, 32'h1111_2222);
    #2;
    rst = 1'b1;
    #1;
    check("async rst req_ready", 32'(req_ready), 32'd1);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("async rst rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("no rsp after reset", 32'(pulses), 32'd0);
    do_req(1'b0, 32'h0000_0020, 32'h0, lat, rdata, fault, single);
    check("dropped store rdata", rdata, 32'h1111_2222);
    check("dropped store latency", 32'(lat), 32'd4);

    // Zero wait-state instance.
    repeat (8) @(negedge clk);
    use_z = 1'b1;
    do_req(1'b1, 32'h0000_0040, 32'h0000_0077, lat, rdata, fault, single);
    check("lat0 store latency", 32'(lat), 32'd2);
    check("lat0 store rdata", rdata, 32'd0);
    do_req(1'b0, 32'h0000_0040, 32'h0, lat, rdata, fault, single);
    check("lat0 load latency", 32'(lat), 32'd2);
    check("lat0 load rdata", rdata, 32'h0000_0077);
    check("lat0 one-cycle strobe", 32'(single), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
